mem_stage_lsu: RTL and testbench

MEM_STAGE_LSU -- requirements
Module: mem_stage_lsu

---
 rtl/mem_stage_pkg.sv | 74 +++++++
 rtl/lsu_byte_ram.sv | 34 +++
 rtl/mem_stage_lsu.sv | 170 +++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Purpose: shared encodings, FSM states and helpers for the load/store unit.
// Latency: combinational helpers only.
// Backpressure: none; the package holds no state.
package mem_stage_pkg;

   // Default build-time sizing of the memory stage
   localparam int DEPTH_BYTES_DEFAULT = 256;
   localparam int MEM_LATENCY_DEFAULT = 2;

   // Access-size encodings carried on Size
   localparam logic [1:0] SIZE_BYTE   = 2'b00;
   localparam logic [1:0] SIZE_HALF   = 2'b01;
   localparam logic [1:0] SIZE_WORD   = 2'b10;
   localparam logic [1:0] SIZE_DOUBLE = 2'b11;

   // IDLE accepts work; ACCESS counts down the memory latency
   typedef enum logic {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } lsu_state_e;

   // Snapshot of one accepted instruction, held for the whole access
   typedef struct packed {
      logic [63:0] result;
      logic [63:0] wdata;
      logic [4:0]  rd;
      logic        mem_read;
      logic        mem_write;
      logic        mem_to_reg;
      logic        reg_write;
      logic [1:0]  size;
      logic        zext;
   } lsu_op_t;

   // Byte lanes touched by an access of the given size (lane 0 = lowest address)
   function automatic logic [7:0] size_byte_en(input logic [1:0] size);
      logic [7:0] be;
      case (size)
         SIZE_BYTE: be = 8'h01;
         SIZE_HALF: be = 8'h03;
         SIZE_WORD: be = 8'h0F;
         default:   be = 8'hFF;
      endcase
      return be;
   endfunction

   // An access is misaligned when the address is not a multiple of its size
   function automatic logic is_misaligned(input logic [2:0] addr_lo,
                                          input logic [1:0] size);
      logic mis;
      case (size)
         SIZE_BYTE: mis = 1'b0;
         SIZE_HALF: mis = addr_lo[0];
         SIZE_WORD: mis = |addr_lo[1:0];
         default:   mis = |addr_lo;
      endcase
      return mis;
   endfunction

   // Extend the low size-selected bytes to 64 bits; doubles pass through
   function automatic logic [63:0] load_extend(input logic [63:0] raw,
                                               input logic [1:0]  size,
                                               input logic        zext);
      logic [63:0] ext;
      case (size)
         SIZE_BYTE: ext = zext ? {56'd0, raw[7:0]}  : {{56{raw[7]}},  raw[7:0]};
         SIZE_HALF: ext = zext ? {48'd0, raw[15:0]} : {{48{raw[15]}}, raw[15:0]};
         SIZE_WORD: ext = zext ? {32'd0, raw[31:0]} : {{32{raw[31]}}, raw[31:0]};
         default:   ext = raw;
      endcase
      return ext;
   endfunction

endpackage

// File: rtl/lsu_byte_ram.sv
// Purpose: byte-addressed little-endian data memory, 8-lane write, 64-bit read.
// Latency: read is combinational from i_addr; writes land on the rising edge.
// Backpressure: none; always ready. Contents survive reset.
module lsu_byte_ram #(
   parameter int DEPTH_BYTES = 256,
   localparam int AW = $clog2(DEPTH_BYTES)
) (
   input  logic          clk,
   input  logic [AW-1:0] i_addr,
   input  logic [7:0]    i_be,
   input  logic [63:0]   i_wdata,
   output logic [63:0]   o_rdata
);

   logic [7:0] r_mem [DEPTH_BYTES];

   // Lane i of the write data goes to address i_addr+i when its enable is set
   always_ff @(posedge clk) begin
      for (int i = 0; i < 8; i++) begin
         if (i_be[i]) begin
            r_mem[i_addr + AW'(i)] <= i_wdata[8*i +: 8];
         end
      end
   end

   // Gather eight consecutive bytes, lowest address in the low lane
   always_comb begin
      o_rdata = '0;
      for (int i = 0; i < 8; i++) begin
         o_rdata[8*i +: 8] = r_mem[i_addr + AW'(i)];
      end
   end

endmodule

// File: rtl/mem_stage_lsu.sv
// Purpose: pipeline MEM stage; performs loads/stores against local byte RAM.
// Latency: non-memory and misaligned ops 1 edge; aligned memory ops MEM_LATENCY edges.
// Backpressure: stall is high in ACCESS; upstream holds its instruction until it drops.
module mem_stage_lsu
   import mem_stage_pkg::*;
#(
   parameter int DEPTH_BYTES = DEPTH_BYTES_DEFAULT,
   parameter int MEM_LATENCY = MEM_LATENCY_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   input  logic [63:0] Result,
   input  logic [63:0] Write_Data,
   input  logic [4:0]  rd1,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic        MemtoReg,
   input  logic        RegWrite,
   input  logic [1:0]  Size,
   input  logic        Unsigned,
   output logic        stall,
   output logic        out_valid,
   output logic [63:0] Result_out,
   output logic [63:0] Read_Data,
   output logic [4:0]  rd_out,
   output logic        MemtoReg_out,
   output logic        RegWrite_out,
   output logic        misaligned
);

   localparam int AW    = $clog2(DEPTH_BYTES);
   localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LATENCY - 1);

   lsu_state_e       r_state;
   lsu_state_e       w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   lsu_op_t          r_op;

   logic        w_in_is_mem;
   logic        w_in_misal;
   logic        w_accept;
   logic        w_fast_done;
   logic        w_do_access;
   logic [7:0]  w_be;
   logic [63:0] w_rdata;
   logic [63:0] w_load_dat;

   // Classify the incoming instruction; only aligned memory ops need ACCESS
   assign w_in_is_mem = MemRead | MemWrite;
   assign w_in_misal  = w_in_is_mem & is_misaligned(Result[2:0], Size);

   assign stall = (r_state == ACCESS);

   // State and latency counter; reset aborts any op in flight
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Next-state: accept in IDLE, count down in ACCESS, access when count hits zero
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_accept    = 1'b0;
      w_fast_done = 1'b0;
      w_do_access = 1'b0;
      case (r_state)
         IDLE: begin
            if (in_valid) begin
               w_accept = 1'b1;
               if (w_in_is_mem && !w_in_misal) begin
                  w_state_nxt = ACCESS;
                  w_cnt_nxt   = CNT_INIT;
               end else begin
                  w_fast_done = 1'b1;
               end
            end
         end
         ACCESS: begin
            if (r_cnt != '0) begin
               w_cnt_nxt = r_cnt - CNT_W'(1);
            end else begin
               w_do_access = 1'b1;
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   // Hold a copy of the accepted instruction for the duration of the access
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_op <= '0;
      end else if (w_accept) begin
         r_op.result     <= Result;
         r_op.wdata      <= Write_Data;
         r_op.rd         <= rd1;
         r_op.mem_read   <= MemRead;
         r_op.mem_write  <= MemWrite;
         r_op.mem_to_reg <= MemtoReg;
         r_op.reg_write  <= RegWrite;
         r_op.size       <= Size;
         r_op.zext       <= Unsigned;
      end
   end

   // Store lanes fire only on the access edge; a store wins over a load
   assign w_be = (w_do_access && r_op.mem_write) ? size_byte_en(r_op.size) : 8'h00;

   lsu_byte_ram #(
      .DEPTH_BYTES (DEPTH_BYTES)
   ) u_ram (
      .clk     (clk),
      .i_addr  (r_op.result[AW-1:0]),
      .i_be    (w_be),
      .i_wdata (r_op.wdata),
      .o_rdata (w_rdata)
   );

   assign w_load_dat = (r_op.mem_read && !r_op.mem_write)
                       ? load_extend(w_rdata, r_op.size, r_op.zext)
                       : 64'd0;

   // Write-back outputs: qualifiers pulse for one edge, data fields hold between ops
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_valid    <= 1'b0;
         Result_out   <= '0;
         Read_Data    <= '0;
         rd_out       <= '0;
         MemtoReg_out <= 1'b0;
         RegWrite_out <= 1'b0;
         misaligned   <= 1'b0;
      end else begin
         out_valid    <= 1'b0;
         MemtoReg_out <= 1'b0;
         RegWrite_out <= 1'b0;
         misaligned   <= 1'b0;
         if (w_fast_done) begin
            out_valid    <= 1'b1;
            Result_out   <= Result;
            Read_Data    <= 64'd0;
            rd_out       <= rd1;
            MemtoReg_out <= MemtoReg;
            RegWrite_out <= RegWrite & ~w_in_misal;
            misaligned   <= w_in_misal;
         end else if (w_do_access) begin
            out_valid    <= 1'b1;
            Result_out   <= r_op.result;
            Read_Data    <= w_load_dat;
            rd_out       <= r_op.rd;
            MemtoReg_out <= r_op.mem_to_reg;
            RegWrite_out <= r_op.reg_write;
         end
      end
   end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Purpose: directed scoreboard bench for mem_stage_lsu.
// Latency: expected output edge is tracked per instruction.
// Backpressure: driver holds each instruction while stall is high.
module tb_mem_stage_lsu;

   localparam int L = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic [63:0] Result;
   logic [63:0] Write_Data;
   logic [4:0]  rd1;
   logic        MemRead, MemWrite, MemtoReg, RegWrite;
   logic [1:0]  Size;
   logic        Unsigned;
   logic        stall, out_valid;
   logic [63:0] Result_out, Read_Data;
   logic [4:0]  rd_out;
   logic        MemtoReg_out, RegWrite_out, misaligned;

   typedef struct {
      logic [63:0] res;
      logic [63:0] rdat;
      logic [4:0]  rd;
      logic        m2r;
      logic        rw;
      logic        mis;
      int          edge_n;
   } exp_t;

   exp_t exp_q[$];
   exp_t m_e;
   int   edge_cnt = 0;
   int   n_pass   = 0;
   int   n_total  = 0;
   int   a_edge, b_edge;

   mem_stage_lsu #(.DEPTH_BYTES(256), .MEM_LATENCY(L)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .Result(Result),
      .Write_Data(Write_Data), .rd1(rd1), .MemRead(MemRead), .MemWrite(MemWrite),
      .MemtoReg(MemtoReg), .RegWrite(RegWrite), .Size(Size), .Unsigned(Unsigned),
      .stall(stall), .out_valid(out_valid), .Result_out(Result_out),
      .Read_Data(Read_Data), .rd_out(rd_out), .MemtoReg_out(MemtoReg_out),
      .RegWrite_out(RegWrite_out), .misaligned(misaligned)
   );

   always #5 clk = ~clk;

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   // Monitor: pop and compare on every out_valid; flags must be quiet otherwise
   always @(negedge clk) begin
      if (reset) begin
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               n_total++;
               $display("FAIL unexpected_out: got out_valid=1 Result_out=%h, expected no output", Result_out);
            end else begin
               m_e = exp_q.pop_front();
               chk("out_edge",     64'(edge_cnt),       64'(m_e.edge_n));
               chk("Result_out",   Result_out,          m_e.res);
               chk("Read_Data",    Read_Data,           m_e.rdat);
               chk("rd_out",       64'(rd_out),         64'(m_e.rd));
               chk("ctrl_out",     {61'd0, MemtoReg_out, RegWrite_out, misaligned},
                                   {61'd0, m_e.m2r, m_e.rw, m_e.mis});
            end
         end else begin
            chk("quiet_flags", {61'd0, MemtoReg_out, RegWrite_out, misaligned}, 64'd0);
         end
      end
   end

   task automatic send(input logic [63:0] res, input logic [63:0] wd, input logic [4:0] rd,
                       input logic mr, input logic mw, input logic m2r, input logic rw,
                       input logic [1:0] sz, input logic uns,
                       input logic [63:0] exp_rdat, input logic exp_mis, output int acc_edge);
      exp_t e;
      int   guard;
      @(negedge clk);
      Result = res; Write_Data = wd; rd1 = rd;
      MemRead = mr; MemWrite = mw; MemtoReg = m2r; RegWrite = rw;
      Size = sz; Unsigned = uns; in_valid = 1'b1;
      guard = 0;
      while (stall && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (stall) begin
         n_total++;
         $display("FAIL accept_timeout: got stall=1 after %0d cycles, expected 0", guard);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      acc_edge = edge_cnt;
      e.res    = res;
      e.rdat   = exp_rdat;
      e.rd     = rd;
      e.m2r    = m2r;
      e.rw     = exp_mis ? 1'b0 : rw;
      e.mis    = exp_mis;
      e.edge_n = acc_edge + (((mr | mw) && !exp_mis) ? L : 0);
      exp_q.push_back(e);
   endtask

   task automatic st(input logic [63:0] addr, input logic [63:0] data,
                     input logic [1:0] sz, input logic mis, output int acc_edge);
      send(addr, data, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, sz, 1'b0, 64'd0, mis, acc_edge);
   endtask

   task automatic ld(input logic [63:0] addr, input logic [1:0] sz, input logic uns,
                     input logic [4:0] rd, input logic [63:0] exp, input logic mis);
      int ae;
      send(addr, 64'hFFFF_FFFF_FFFF_FFFF, rd, 1'b1, 1'b0, 1'b1, 1'b1, sz, uns, exp, mis, ae);
   endtask

   task automatic wait_drain();
      int guard = 0;
      while (exp_q.size() != 0 && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (exp_q.size() != 0) begin
         n_total++;
         $display("FAIL drain_timeout: got %0d pending outputs, expected 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   initial begin
      reset = 1'b0; in_valid = 1'b1; Result = 64'h10; Write_Data = 64'hAA;
      rd1 = 5'd1; MemRead = 1'b0; MemWrite = 1'b1; MemtoReg = 1'b0; RegWrite = 1'b1;
      Size = 2'b11; Unsigned = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_Result_out", Result_out, 64'd0);
      chk("rst_Read_Data",  Read_Data,  64'd0);
      chk("rst_ctrl", {57'd0, stall, out_valid, MemtoReg_out, RegWrite_out, misaligned, 2'b00},
                      64'd0);
      chk("rst_rd_out", 64'(rd_out), 64'd0);
      @(negedge clk);
      in_valid = 1'b0;
      reset    = 1'b1;

      // Scenario 1: double store, stall for L cycles, read back
      st(64'h10, 64'h1122334455667788, 2'b11, 1'b0, a_edge);
      chk("s1_stall_c0", 64'(stall), 64'd1);
      @(posedge clk); #1;
      chk("s1_stall_c1", 64'(stall), 64'd1);
      @(posedge clk); #1;
      chk("s1_stall_done", {62'd0, stall, out_valid}, 64'd1);
      wait_drain();
      ld(64'h10, 2'b11, 1'b0, 5'd5, 64'h1122334455667788, 1'b0);

      // Scenario 2: byte store touches one lane; sign vs zero extension
      st(64'h10, 64'h0123456789ABCD88, 2'b00, 1'b0, a_edge);
      ld(64'h10, 2'b00, 1'b0, 5'd6, 64'hFFFF_FFFF_FFFF_FF88, 1'b0);
      ld(64'h10, 2'b00, 1'b1, 5'd6, 64'h0000_0000_0000_0088, 1'b0);
      ld(64'h10, 2'b11, 1'b0, 5'd6, 64'h1122334455667788, 1'b0);
      st(64'h14, 64'h0000_0000_0000_BEEF, 2'b01, 1'b0, a_edge);
      ld(64'h14, 2'b01, 1'b0, 5'd7, 64'hFFFF_FFFF_FFFF_BEEF, 1'b0);
      ld(64'h14, 2'b10, 1'b1, 5'd7, 64'h0000_0000_1122_BEEF, 1'b0);
      ld(64'h10, 2'b10, 1'b0, 5'd7, 64'h0000_0000_5566_7788, 1'b0);
      ld(64'h16, 2'b01, 1'b1, 5'd7, 64'h0000_0000_0000_1122, 1'b0);
      ld(64'h110, 2'b11, 1'b0, 5'd8, 64'h1122_BEEF_5566_7788, 1'b0);

      // Scenario 3: misaligned ops complete in one edge and touch nothing
      ld(64'h12, 2'b10, 1'b0, 5'd7, 64'd0, 1'b1);
      st(64'h12, 64'hFFFF_FFFF_FFFF_FFFF, 2'b10, 1'b1, a_edge);
      ld(64'h11, 2'b01, 1'b0, 5'd2, 64'd0, 1'b1);
      ld(64'h14, 2'b11, 1'b0, 5'd2, 64'd0, 1'b1);
      ld(64'h10, 2'b11, 1'b0, 5'd2, 64'h1122_BEEF_5566_7788, 1'b0);

      // Scenario 4: non-memory op held behind a store in ACCESS
      st(64'h18, 64'hCAFE_F00D_1234_5678, 2'b11, 1'b0, a_edge);
      send(64'd5, 64'd0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 1'b0, 64'd0, 1'b0, b_edge);
      chk("s4_hold_edges", 64'(b_edge - a_edge), 64'(L + 1));
      ld(64'h18, 2'b11, 1'b0, 5'd4, 64'hCAFE_F00D_1234_5678, 1'b0);

      // Read and write together: store wins, Read_Data is zero
      send(64'h20, 64'h0A0B_0C0D_0E0F_1011, 5'd9, 1'b1, 1'b1, 1'b1, 1'b1, 2'b11, 1'b0,
           64'd0, 1'b0, a_edge);
      ld(64'h20, 2'b11, 1'b0, 5'd9, 64'h0A0B_0C0D_0E0F_1011, 1'b0);
      wait_drain();

      // Scenario 5: reset mid-ACCESS aborts the store
      st(64'h20, 64'hDEAD_BEEF_DEAD_BEEF, 2'b11, 1'b0, a_edge);
      void'(exp_q.pop_back());
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("s5_rst_Result_out", Result_out, 64'd0);
      chk("s5_rst_Read_Data",  Read_Data,  64'd0);
      chk("s5_rst_ctrl", {58'd0, stall, out_valid, MemtoReg_out, RegWrite_out, misaligned, 1'b0},
                         64'd0);
      chk("s5_rst_rd_out", 64'(rd_out), 64'd0);
      @(negedge clk);
      reset = 1'b1;
      repeat (4) @(negedge clk);
      ld(64'h20, 2'b11, 1'b0, 5'd10, 64'h0A0B_0C0D_0E0F_1011, 1'b0);
      wait_drain();
      repeat (4) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
